// File: rtl/or1200_qmem_pkg.sv
// Shared definitions for the QMEM controller: FSM state codes, arbitration
// mode selectors and the address-window hit test.
package or1200_qmem_pkg;

    // State codes are visible on state_o and are fixed for external checkers.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_STORE = 3'd1,
        ST_LOAD  = 3'd2,
        ST_FETCH = 3'd3
    } qmem_state_t;

    localparam int ARB_DATA_PRIO   = 0;
    localparam int ARB_ROUND_ROBIN = 1;

    // Window comparison is done at a fixed wide width so one function serves any AW.
    localparam int HIT_W = 64;

    function automatic logic qmem_hit(input logic [HIT_W-1:0] adr,
                                      input logic [HIT_W-1:0] mask,
                                      input logic [HIT_W-1:0] base);
        return (adr & mask) == base;
    endfunction

endpackage

// File: rtl/or1200_qmem_arb.sv
// Two-way arbiter between the data and fetch channels. With data priority the
// data channel always wins a tie; in round-robin mode the channel that was not
// granted last wins. The last grant is remembered on every grant.
module or1200_qmem_arb
    import or1200_qmem_pkg::*;
#(
    parameter int ARB_MODE = ARB_DATA_PRIO
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req_d,
    input  logic i_req_i,
    output logic o_gnt_d,
    output logic o_gnt_i
);

    // 1 = fetch channel was granted most recently; reset favours data first.
    logic r_last_fetch;

    // Resolve the grant from the current requests and the last-grant history.
    always_comb begin
        o_gnt_d = 1'b0;
        o_gnt_i = 1'b0;
        if (i_req_d && i_req_i) begin
            if (ARB_MODE == ARB_ROUND_ROBIN && !r_last_fetch) begin
                o_gnt_i = 1'b1;
            end else begin
                o_gnt_d = 1'b1;
            end
        end else begin
            o_gnt_d = i_req_d;
            o_gnt_i = i_req_i;
        end
    end

    // Remember which channel took the most recent grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_fetch <= 1'b1;
        end else if (o_gnt_d) begin
            r_last_fetch <= 1'b0;
        end else if (o_gnt_i) begin
            r_last_fetch <= 1'b1;
        end
    end

endmodule

// File: rtl/or1200_qmem_ctrl.sv
// QMEM controller: shares one single-port synchronous RAM between the fetch
// and load/store channels. A grant issues the single RAM access of a request;
// the ack follows 1+WAIT_CYC cycles later, and the next grant may overlap the
// ack cycle so back-to-back accesses need no idle bubble.
module or1200_qmem_ctrl
    import or1200_qmem_pkg::*;
#(
    parameter int            AW       = 32,
    parameter int            MEM_AW   = 11,
    parameter logic [AW-1:0] BASE     = 32'h0000_0000,
    parameter logic [AW-1:0] MASK     = 32'hFFFF_E000,
    parameter int            WAIT_CYC = 0,
    parameter int            ARB_MODE = ARB_DATA_PRIO
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cycstb,
    input  logic [AW-1:0]     i_adr,
    output logic              i_hit,
    output logic              i_ack,
    output logic [31:0]       i_dat,
    input  logic              d_cycstb,
    input  logic              d_we,
    input  logic [3:0]        d_sel,
    input  logic [AW-1:0]     d_adr,
    input  logic [31:0]       d_dat_i,
    output logic              d_hit,
    output logic              d_ack,
    output logic [31:0]       d_dat_o,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [MEM_AW-1:0] ram_addr,
    output logic [31:0]       ram_di,
    input  logic [31:0]       ram_do,
    output logic [2:0]        state_o
);

    localparam logic [2:0] W_WAIT = 3'(WAIT_CYC);

    qmem_state_t r_state;
    qmem_state_t w_state_next;
    logic [2:0]  r_wait_cnt;

    logic w_i_valid;
    logic w_d_valid;
    logic w_wait_done;
    logic w_open_i;
    logic w_open_d;
    logic w_end;
    logic w_ack_i;
    logic w_ack_d;
    logic w_gnt_i;
    logic w_gnt_d;

    assign i_hit       = qmem_hit(HIT_W'(i_adr), HIT_W'(MASK), HIT_W'(BASE));
    assign d_hit       = qmem_hit(HIT_W'(d_adr), HIT_W'(MASK), HIT_W'(BASE));
    assign w_i_valid   = i_cycstb & i_hit;
    assign w_d_valid   = d_cycstb & d_hit;
    assign w_wait_done = (r_wait_cnt == W_WAIT);

    // Decode the current access: ack, abort, and which channels may be granted now.
    always_comb begin
        w_ack_d  = 1'b0;
        w_ack_i  = 1'b0;
        w_open_d = 1'b0;
        w_open_i = 1'b0;
        w_end    = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_IDLE: begin
                    w_open_d = 1'b1;
                    w_open_i = 1'b1;
                end
                ST_STORE, ST_LOAD: begin
                    if (!w_d_valid) begin
                        w_end = 1'b1;
                    end else if (w_wait_done) begin
                        w_ack_d  = 1'b1;
                        w_end    = 1'b1;
                        w_open_i = 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (!w_i_valid) begin
                        w_end = 1'b1;
                    end else if (w_wait_done) begin
                        w_ack_i  = 1'b1;
                        w_end    = 1'b1;
                        w_open_d = 1'b1;
                    end
                end
                default: w_end = 1'b1;
            endcase
        end
    end

    or1200_qmem_arb #(
        .ARB_MODE(ARB_MODE)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_req_d (w_open_d & w_d_valid),
        .i_req_i (w_open_i & w_i_valid),
        .o_gnt_d (w_gnt_d),
        .o_gnt_i (w_gnt_i)
    );

    // A grant always starts a new access; otherwise a finished or aborted access returns to idle.
    always_comb begin
        w_state_next = r_state;
        if (w_gnt_d) begin
            w_state_next = d_we ? ST_STORE : ST_LOAD;
        end else if (w_gnt_i) begin
            w_state_next = ST_FETCH;
        end else if (w_end) begin
            w_state_next = ST_IDLE;
        end
    end

    // State register and wait counter; the counter restarts at every grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 3'd0;
        end else begin
            r_state <= w_state_next;
            if (w_gnt_d || w_gnt_i || w_end) begin
                r_wait_cnt <= 3'd0;
            end else if (r_state != ST_IDLE) begin
                r_wait_cnt <= r_wait_cnt + 3'd1;
            end
        end
    end

    // Byte-lane write enables only on a store grant.
    for (genvar gi = 0; gi < 4; gi++) begin : g_we_lane
        assign ram_we[gi] = w_gnt_d & d_we & d_sel[gi];
    end

    assign ram_en   = w_gnt_d | w_gnt_i;
    assign ram_addr = w_gnt_d ? d_adr[MEM_AW+1:2] : i_adr[MEM_AW+1:2];
    assign ram_di   = d_dat_i;
    assign i_ack    = w_ack_i;
    assign d_ack    = w_ack_d;
    assign i_dat    = ram_do;
    assign d_dat_o  = ram_do;
    assign state_o  = r_state;

endmodule

// File: tb/tb_or1200_qmem_ctrl.sv
// Randomized bench for the QMEM controller. Two instances run side by side:
// instance 0 with zero wait states and data priority, instance 1 with two wait
// states and round-robin. A transaction-level model (owner, cycles remaining,
// memory image) predicts every output cycle by cycle.
module tb_or1200_qmem_ctrl;

    localparam int N    = 2;
    localparam int NCYC = 1500;
    localparam int DEPTH = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic mem_init;

    logic        i_cycstb [N];
    logic [31:0] i_adr    [N];
    logic        i_hit    [N];
    logic        i_ack    [N];
    logic [31:0] i_dat    [N];
    logic        d_cycstb [N];
    logic        d_we     [N];
    logic [3:0]  d_sel    [N];
    logic [31:0] d_adr    [N];
    logic [31:0] d_dat_i  [N];
    logic        d_hit    [N];
    logic        d_ack    [N];
    logic [31:0] d_dat_o  [N];
    logic        ram_en   [N];
    logic [3:0]  ram_we   [N];
    logic [10:0] ram_addr [N];
    logic [31:0] ram_di   [N];
    logic [31:0] ram_do   [N];
    logic [2:0]  state_o  [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        or1200_qmem_ctrl #(
            .AW       (32),
            .MEM_AW   (11),
            .BASE     (32'h0000_0000),
            .MASK     (32'hFFFF_E000),
            .WAIT_CYC ((gi == 0) ? 0 : 2),
            .ARB_MODE (gi)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .i_cycstb (i_cycstb[gi]),
            .i_adr    (i_adr[gi]),
            .i_hit    (i_hit[gi]),
            .i_ack    (i_ack[gi]),
            .i_dat    (i_dat[gi]),
            .d_cycstb (d_cycstb[gi]),
            .d_we     (d_we[gi]),
            .d_sel    (d_sel[gi]),
            .d_adr    (d_adr[gi]),
            .d_dat_i  (d_dat_i[gi]),
            .d_hit    (d_hit[gi]),
            .d_ack    (d_ack[gi]),
            .d_dat_o  (d_dat_o[gi]),
            .ram_en   (ram_en[gi]),
            .ram_we   (ram_we[gi]),
            .ram_addr (ram_addr[gi]),
            .ram_di   (ram_di[gi]),
            .ram_do   (ram_do[gi]),
            .state_o  (state_o[gi])
        );
    end

    function automatic logic [31:0] mem_pat(input int k, input int a);
        return (32'h9E37_79B9 * 32'(a + 1)) ^ 32'(k * 32'h0101_0101);
    endfunction

    // Behavioural single-port RAM behind each instance (read-first).
    logic [31:0] ram_mem [N][DEPTH];
    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (mem_init) begin
                for (int a = 0; a < DEPTH; a++) ram_mem[k][a] <= mem_pat(k, a);
            end
            if (rst) begin
                ram_do[k] <= 32'h0;
            end else if (ram_en[k]) begin
                ram_do[k] <= ram_mem[k][ram_addr[k]];
                for (int b = 0; b < 4; b++)
                    if (ram_we[k][b]) ram_mem[k][ram_addr[k]][8*b +: 8] <= ram_di[k][8*b +: 8];
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: owner 0 = none, 1 = data, 2 = fetch.
    int          m_busy       [N];
    int          m_due        [N];
    logic        m_we         [N];
    logic        m_last_fetch [N];
    logic [31:0] m_data       [N];
    logic        m_dack_prev  [N];
    logic        m_iack_prev  [N];
    logic [31:0] ref_mem      [N][DEPTH];
    int          m_wait       [N];

    // Master-side bookkeeping.
    logic d_pend [N];
    logic d_miss [N];
    logic i_pend [N];
    logic i_miss [N];

    function automatic logic [31:0] pick_adr(input logic miss);
        logic [31:0] a;
        if (miss) begin
            if ($urandom_range(0, 1) == 0) a = 32'h4000_0000 | ($urandom & 32'h0FFF_FFFC);
            else                           a = 32'h0000_2000 + 32'($urandom_range(0, 255)) * 32'd4;
        end else if ($urandom_range(0, 4) != 0) begin
            a = 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
        end else begin
            a = 32'($urandom_range(0, 32'h1FFF));
        end
        return a;
    endfunction

    // Each master holds its request until ack, occasionally aborts, and
    // never re-raises cycstb in the same cycle as an abort.
    task automatic drive(input int k);
        logic keep;
        keep = d_pend[k] && !m_dack_prev[k];
        if (d_pend[k] && !m_dack_prev[k] &&
            ($urandom_range(0, 19) == 0 || (d_miss[k] && $urandom_range(0, 3) == 0))) begin
            d_pend[k] = 1'b0;
            d_cycstb[k] = 1'b0;
        end else if (!keep) begin
            d_pend[k] = 1'b0;
            d_cycstb[k] = 1'b0;
            if ($urandom_range(0, 9) < 7) begin
                d_pend[k]   = 1'b1;
                d_cycstb[k] = 1'b1;
                d_miss[k]   = ($urandom_range(0, 9) == 0);
                d_adr[k]    = pick_adr(d_miss[k]);
                d_we[k]     = 1'($urandom_range(0, 1));
                d_sel[k]    = 4'($urandom);
                d_dat_i[k]  = $urandom;
            end
        end
        keep = i_pend[k] && !m_iack_prev[k];
        if (i_pend[k] && !m_iack_prev[k] &&
            ($urandom_range(0, 19) == 0 || (i_miss[k] && $urandom_range(0, 3) == 0))) begin
            i_pend[k] = 1'b0;
            i_cycstb[k] = 1'b0;
        end else if (!keep) begin
            i_pend[k] = 1'b0;
            i_cycstb[k] = 1'b0;
            if ($urandom_range(0, 9) < 7) begin
                i_pend[k]   = 1'b1;
                i_cycstb[k] = 1'b1;
                i_miss[k]   = ($urandom_range(0, 9) == 0);
                i_adr[k]    = pick_adr(i_miss[k]);
            end
        end
    endtask

    // Predict this cycle's outputs from the model, compare, then advance the model.
    task automatic model_check(input int k);
        logic        hd, hi, vd, vi, may_d, may_i, e_dack, e_iack;
        int          gnt;
        logic [31:0] ga;
        logic [10:0] wa;
        logic [2:0]  e_state;
        logic [3:0]  e_we;

        hd = (d_adr[k] < 32'h2000);
        hi = (i_adr[k] < 32'h2000);
        vd = d_cycstb[k] & hd;
        vi = i_cycstb[k] & hi;
        e_state = (m_busy[k] == 0) ? 3'd0 : (m_busy[k] == 2) ? 3'd3 : (m_we[k] ? 3'd1 : 3'd2);

        may_d = 1'b0; may_i = 1'b0; e_dack = 1'b0; e_iack = 1'b0; gnt = 0;
        if (!rst) begin
            if (m_busy[k] == 0) begin
                may_d = vd;
                may_i = vi;
            end else if (m_busy[k] == 1) begin
                if (vd && m_due[k] == 0) begin e_dack = 1'b1; may_i = vi; end
            end else begin
                if (vi && m_due[k] == 0) begin e_iack = 1'b1; may_d = vd; end
            end
        end
        if (may_d && may_i) gnt = (k == 0 || m_last_fetch[k]) ? 1 : 2;
        else if (may_d)     gnt = 1;
        else if (may_i)     gnt = 2;

        ga   = (gnt == 1) ? d_adr[k] : i_adr[k];
        wa   = ga[12:2];
        e_we = (gnt == 1 && d_we[k]) ? d_sel[k] : 4'h0;

        check_eq($sformatf("d_hit[%0d]", k), 32'(d_hit[k]), 32'(hd));
        check_eq($sformatf("i_hit[%0d]", k), 32'(i_hit[k]), 32'(hi));
        check_eq($sformatf("state[%0d]", k), 32'(state_o[k]), 32'(e_state));
        check_eq($sformatf("d_ack[%0d]", k), 32'(d_ack[k]), 32'(e_dack));
        check_eq($sformatf("i_ack[%0d]", k), 32'(i_ack[k]), 32'(e_iack));
        check_eq($sformatf("ram_en[%0d]", k), 32'(ram_en[k]), 32'(gnt != 0));
        check_eq($sformatf("ram_we[%0d]", k), 32'(ram_we[k]), 32'(e_we));
        if (gnt != 0) check_eq($sformatf("ram_addr[%0d]", k), 32'(ram_addr[k]), 32'(wa));
        if (e_dack && !m_we[k]) check_eq($sformatf("d_dat_o[%0d]", k), d_dat_o[k], m_data[k]);
        if (e_iack)             check_eq($sformatf("i_dat[%0d]", k), i_dat[k], m_data[k]);

        if (e_dack) $display("txn dut%0d %s adr=%h data=%h", k, m_we[k] ? "ST" : "LD", d_adr[k],
                             m_we[k] ? d_dat_i[k] : m_data[k]);
        if (e_iack) $display("txn dut%0d IF adr=%h data=%h", k, i_adr[k], m_data[k]);

        if (rst) begin
            m_busy[k] = 0;
            m_last_fetch[k] = 1'b1;
        end else if (gnt != 0) begin
            m_busy[k] = gnt;
            m_due[k]  = m_wait[k];
            m_last_fetch[k] = (gnt == 2);
            m_we[k] = (gnt == 1) && d_we[k];
            if (m_we[k]) begin
                for (int b = 0; b < 4; b++)
                    if (d_sel[k][b]) ref_mem[k][wa][8*b +: 8] = d_dat_i[k][8*b +: 8];
            end else begin
                m_data[k] = ref_mem[k][wa];
            end
        end else if (m_busy[k] != 0) begin
            if (e_dack || e_iack || (m_busy[k] == 1 && !vd) || (m_busy[k] == 2 && !vi)) m_busy[k] = 0;
            else m_due[k] = m_due[k] - 1;
        end
        m_dack_prev[k] = e_dack;
        m_iack_prev[k] = e_iack;
    endtask

    initial begin
        rst = 1'b1;
        mem_init = 1'b1;
        for (int k = 0; k < N; k++) begin
            i_cycstb[k] = 1'b0; i_adr[k] = 32'h0;
            d_cycstb[k] = 1'b0; d_we[k] = 1'b0; d_sel[k] = 4'h0; d_adr[k] = 32'h0; d_dat_i[k] = 32'h0;
            m_busy[k] = 0; m_due[k] = 0; m_we[k] = 1'b0; m_last_fetch[k] = 1'b1; m_data[k] = 32'h0;
            m_dack_prev[k] = 1'b0; m_iack_prev[k] = 1'b0;
            d_pend[k] = 1'b0; d_miss[k] = 1'b0; i_pend[k] = 1'b0; i_miss[k] = 1'b0;
            m_wait[k] = (k == 0) ? 0 : 2;
            for (int a = 0; a < DEPTH; a++) ref_mem[k][a] = mem_pat(k, a);
        end
        repeat (2) @(posedge clk);
        #1 mem_init = 1'b0;

        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            rst = (c < 2) || (c >= 700 && c < 702);
            for (int k = 0; k < N; k++) drive(k);
            #1;
            for (int k = 0; k < N; k++) model_check(k);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
